// File: rtl/branch_checkpoint_queue.sv
// rtl/branch_checkpoint_queue.sv - in-order checkpoint FIFO for predicted branches with predictor update on resolve
//
// Holds {pc, global history, local history, prediction} for each in-flight
// branch. The oldest entry is resolved in order. One cycle after a resolve is
// accepted, the block emits a registered predictor-update pulse with corrected
// histories. A mispredict flushes every younger entry on the same edge.
//
// Ports:
//   clk, reset (async, active-low)
//   push_valid/push_ready, push_pc, push_ghist, push_lhist, push_prediction
//   resolve_valid, resolve_outcome
//   write_enabled, outcome, pc_bits_write, global_history_write,
//   local_history_write, branch_miss (registered update outputs)
//   count, resolve_underflow (sticky)
//   stat_resolved, stat_miss (present only with BCQ_STATS_EN defined)
//
// Optional feature macro: BCQ_STATS_EN

module branch_checkpoint_queue #(
  parameter int GLOBAL_HISTORY_LEN = 8,
  parameter int LOCAL_HISTORY_LEN  = 10,
  parameter int DEPTH              = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          push_valid,
  output logic                          push_ready,
  input  logic [15:0]                   push_pc,
  input  logic [GLOBAL_HISTORY_LEN-1:0] push_ghist,
  input  logic [LOCAL_HISTORY_LEN-1:0]  push_lhist,
  input  logic                          push_prediction,
  input  logic                          resolve_valid,
  input  logic                          resolve_outcome,
  output logic                          write_enabled,
  output logic                          outcome,
  output logic [15:0]                   pc_bits_write,
  output logic [GLOBAL_HISTORY_LEN-1:0] global_history_write,
  output logic [LOCAL_HISTORY_LEN-1:0]  local_history_write,
  output logic                          branch_miss,
  output logic [$clog2(DEPTH):0]        count,
  output logic                          resolve_underflow
`ifdef BCQ_STATS_EN
  ,
  output logic [15:0]                   stat_resolved,
  output logic [15:0]                   stat_miss
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  // The oldest history bit is shifted out on update, so only the low bits
  // of each snapshot are ever needed.
  logic [15:0]                   mem_pc    [DEPTH];
  logic [GLOBAL_HISTORY_LEN-2:0] mem_ghist [DEPTH];
  logic [LOCAL_HISTORY_LEN-2:0]  mem_lhist [DEPTH];
  logic                          mem_pred  [DEPTH];

  logic unused_hist_msb;
  assign unused_hist_msb = ^{push_ghist[GLOBAL_HISTORY_LEN-1], push_lhist[LOCAL_HISTORY_LEN-1]};

  logic [PW-1:0] rd_ptr, wr_ptr;
  logic          resolve_fire, miss, push_fire;

  assign push_ready   = (count != FULL);
  assign resolve_fire = resolve_valid && (count != '0);
  assign miss         = resolve_fire && (mem_pred[rd_ptr] != resolve_outcome);
  // A flush on the same edge wins over a push.
  assign push_fire    = push_valid && push_ready && !miss;

  always_ff @(posedge clk) begin
    if (push_fire) begin
      mem_pc[wr_ptr]    <= push_pc;
      mem_ghist[wr_ptr] <= push_ghist[GLOBAL_HISTORY_LEN-2:0];
      mem_lhist[wr_ptr] <= push_lhist[LOCAL_HISTORY_LEN-2:0];
      mem_pred[wr_ptr]  <= push_prediction;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (miss) begin
      rd_ptr <= wr_ptr;
      count  <= '0;
    end else begin
      if (push_fire) wr_ptr <= wr_ptr + 1'b1;
      if (resolve_fire) rd_ptr <= rd_ptr + 1'b1;
      case ({push_fire, resolve_fire})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      write_enabled        <= 1'b0;
      outcome              <= 1'b0;
      pc_bits_write        <= '0;
      global_history_write <= '0;
      local_history_write  <= '0;
      branch_miss          <= 1'b0;
      resolve_underflow    <= 1'b0;
    end else begin
      write_enabled <= resolve_fire;
      branch_miss   <= miss;
      if (resolve_fire) begin
        outcome              <= resolve_outcome;
        pc_bits_write        <= mem_pc[rd_ptr];
        global_history_write <= {mem_ghist[rd_ptr], resolve_outcome};
        local_history_write  <= {mem_lhist[rd_ptr], resolve_outcome};
      end
      if (resolve_valid && count == '0) resolve_underflow <= 1'b1;
    end
  end

`ifdef BCQ_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_resolved <= '0;
      stat_miss     <= '0;
    end else begin
      if (resolve_fire && stat_resolved != 16'hFFFF) stat_resolved <= stat_resolved + 16'd1;
      if (miss && stat_miss != 16'hFFFF) stat_miss <= stat_miss + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_checkpoint_queue.sv
// tb/tb_branch_checkpoint_queue.sv - randomized and directed self-checking bench for branch_checkpoint_queue

module tb_branch_checkpoint_queue;
  localparam int GL = 8;
  localparam int LL = 10;
  localparam int D  = 8;
  localparam int CW = 4;

  logic          clk = 0;
  logic          reset = 0;
  logic          push_valid = 0, push_prediction = 0;
  logic [15:0]   push_pc = 0;
  logic [GL-1:0] push_ghist = 0;
  logic [LL-1:0] push_lhist = 0;
  logic          resolve_valid = 0, resolve_outcome = 0;
  logic          push_ready, write_enabled, outcome, branch_miss, resolve_underflow;
  logic [15:0]   pc_bits_write;
  logic [GL-1:0] global_history_write;
  logic [LL-1:0] local_history_write;
  logic [CW-1:0] count;
`ifdef BCQ_STATS_EN
  logic [15:0]   stat_resolved, stat_miss;
`endif

  branch_checkpoint_queue #(.GLOBAL_HISTORY_LEN(GL), .LOCAL_HISTORY_LEN(LL), .DEPTH(D)) dut (
    .clk(clk), .reset(reset),
    .push_valid(push_valid), .push_ready(push_ready), .push_pc(push_pc),
    .push_ghist(push_ghist), .push_lhist(push_lhist), .push_prediction(push_prediction),
    .resolve_valid(resolve_valid), .resolve_outcome(resolve_outcome),
    .write_enabled(write_enabled), .outcome(outcome), .pc_bits_write(pc_bits_write),
    .global_history_write(global_history_write), .local_history_write(local_history_write),
    .branch_miss(branch_miss), .count(count), .resolve_underflow(resolve_underflow)
`ifdef BCQ_STATS_EN
    , .stat_resolved(stat_resolved), .stat_miss(stat_miss)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0]   pc;
    logic [GL-1:0] g;
    logic [LL-1:0] l;
    logic          p;
  } ent_t;

  ent_t q[$];
  logic          e_we, e_out, e_miss, e_uf;
  logic [15:0]   e_pc;
  logic [GL-1:0] e_g;
  logic [LL-1:0] e_l;
  int            e_sr, e_sm;
  int            n_tests = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    q.delete();
    e_we = 0; e_out = 0; e_miss = 0; e_uf = 0;
    e_pc = 0; e_g = 0; e_l = 0; e_sr = 0; e_sm = 0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".count"}, 32'(count), 32'(q.size()));
    chk({tag, ".ready"}, 32'(push_ready), 32'(q.size() != D));
    chk({tag, ".we"}, 32'(write_enabled), 32'(e_we));
    chk({tag, ".miss"}, 32'(branch_miss), 32'(e_miss));
    chk({tag, ".outcome"}, 32'(outcome), 32'(e_out));
    chk({tag, ".pc"}, 32'(pc_bits_write), 32'(e_pc));
    chk({tag, ".ghist"}, 32'(global_history_write), 32'(e_g));
    chk({tag, ".lhist"}, 32'(local_history_write), 32'(e_l));
    chk({tag, ".underflow"}, 32'(resolve_underflow), 32'(e_uf));
`ifdef BCQ_STATS_EN
    chk({tag, ".stat_res"}, 32'(stat_resolved), 32'(e_sr));
    chk({tag, ".stat_miss"}, 32'(stat_miss), 32'(e_sm));
`endif
  endtask

  // Called at a falling edge: drive inputs, advance the model, then check
  // outputs at the next falling edge.
  task automatic cycle(input string tag, input logic pv, input logic [15:0] pc,
                       input logic [GL-1:0] g, input logic [LL-1:0] l, input logic p,
                       input logic rv, input logic ro);
    bit fire, full, mp;
    push_valid = pv; push_pc = pc; push_ghist = g; push_lhist = l; push_prediction = p;
    resolve_valid = rv; resolve_outcome = ro;
    full = (q.size() == D);
    fire = rv && (q.size() != 0);
    mp = 0;
    if (fire) begin
      ent_t h = q.pop_front();
      mp = (h.p != ro);
      e_we = 1; e_out = ro; e_miss = mp; e_pc = h.pc;
      e_g = {h.g[GL-2:0], ro};
      e_l = {h.l[LL-2:0], ro};
      if (e_sr < 16'hFFFF) e_sr++;
      if (mp) begin
        q.delete();
        if (e_sm < 16'hFFFF) e_sm++;
      end
    end else begin
      e_we = 0; e_miss = 0;
      if (rv) e_uf = 1;
    end
    if (pv && !full && !mp) q.push_back('{pc, g, l, p});
    @(negedge clk);
    push_valid = 0; resolve_valid = 0;
    check_all(tag);
  endtask

  task automatic push1(input logic [15:0] pc, input logic p);
    cycle("push", 1, pc, GL'($urandom), LL'($urandom), p, 0, 0);
  endtask

  task automatic resolve1(input logic ro);
    cycle("resolve", 0, 0, 0, 0, 0, 1, ro);
  endtask

  task automatic mid_reset();
    #2 reset = 0;
    #1;
    model_clear();
    chk("rst_async.count", 32'(count), 0);
    chk("rst_async.we", 32'(write_enabled), 0);
    @(negedge clk);
    resolve_valid = 1; resolve_outcome = 1;
    @(negedge clk);
    reset = 1; resolve_valid = 0;
    @(negedge clk);
    check_all("after_reset");
  endtask

  initial begin
    model_clear();
    repeat (2) @(negedge clk);
    check_all("reset");
    reset = 1;
    @(negedge clk);

    // Single correct resolve with known ghist
    cycle("d36_push", 1, 16'h0010, 8'hA5, 10'h2F3, 1, 0, 0);
    resolve1(1);
    chk("d36.ghist", 32'(global_history_write), 32'h4B);
    chk("d36.pc", 32'(pc_bits_write), 32'h0010);

    // Mispredict flushes younger entries, then underflow
    push1(16'h0100, 1); push1(16'h0104, 1); push1(16'h0108, 0);
    chk("d37.count3", 32'(count), 3);
    resolve1(0);
    chk("d37.miss", 32'(branch_miss), 1);
    chk("d37.count0", 32'(count), 0);
    resolve1(1);
    chk("d37.underflow", 32'(resolve_underflow), 1);
    mid_reset();

    // Full queue, 9th push ignored even with a freeing resolve
    for (int i = 0; i < D; i++) push1(16'h0200 + 16'(i), 1);
    chk("d38.ready", 32'(push_ready), 0);
    cycle("d38_9th", 1, 16'hDEAD, 0, 0, 1, 1, 1);
    chk("d38.count7", 32'(count), 7);
    for (int i = 0; i < 7; i++) resolve1(1);

    // Interleaved push/resolve across pointer wrap
    push1(16'h0300, 1);
    for (int i = 1; i < 12; i++)
      cycle("d39", 1, 16'h0300 + 16'(i), GL'($urandom), LL'($urandom), 1, 1, 1);
    resolve1(1);
    chk("d39.lastpc", 32'(pc_bits_write), 32'h030B);
    chk("d39.count0", 32'(count), 0);

    // Reset with five entries in flight
    for (int i = 0; i < 5; i++) push1(16'h0400 + 16'(i), 0);
    mid_reset();

    // Random traffic; resolves mostly agree with the head prediction
    for (int n = 0; n < 3000; n++) begin
      logic rv, ro;
      rv = ($urandom_range(0, 2) == 0);
      if (q.size() != 0 && $urandom_range(0, 7) != 0) ro = q[0].p;
      else ro = 1'($urandom);
      cycle("rand", 1'($urandom_range(0, 1)), 16'($urandom), GL'($urandom), LL'($urandom),
            1'($urandom), rv, ro);
      if (n == 1500) mid_reset();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/branch_checkpoint_queue.md
BRANCH_CHECKPOINT_QUEUE -- requirements
Module: branch_checkpoint_queue

Interface
REQ-001 Parameters SHALL be: GLOBAL_HISTORY_LEN, default 8, global history width; LOCAL_HISTORY_LEN, default 10, local history width; DEPTH, default 8, entry count, power of two, minimum 2.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 push_valid  input  1  predicted branch enters queue this cycle.
REQ-005 push_ready  output  1  queue can accept a push (not full).
REQ-006 push_pc  input  16  PC of predicted branch.
REQ-007 push_ghist  input  GLOBAL_HISTORY_LEN  global history snapshot used at prediction.
REQ-008 push_lhist  input  LOCAL_HISTORY_LEN  local history snapshot used at prediction.
REQ-009 push_prediction  input  1  direction predicted (1 = taken).
REQ-010 resolve_valid  input  1  oldest in-flight branch resolved this cycle.
REQ-011 resolve_outcome  input  1  actual direction of resolved branch.
REQ-012 write_enabled, outcome  output  1 each  predictor update strobe and actual direction.
REQ-013 pc_bits_write  output  16  PC of resolved branch.
REQ-014 global_history_write  output  GLOBAL_HISTORY_LEN  corrected global history.
REQ-015 local_history_write  output  LOCAL_HISTORY_LEN  corrected local history.
REQ-016 branch_miss  output  1  resolved branch was mispredicted.
REQ-017 count  output  $clog2(DEPTH)+1  occupied entries.
REQ-018 resolve_underflow  output  1  sticky: resolve arrived while empty.

Function
REQ-019 Queue SHALL be in-order FIFO of {pc, ghist, lhist, prediction}; head = oldest.
REQ-020 Push SHALL occur when push_valid && push_ready; push_ready = (count != DEPTH), combinational from count only.
REQ-021 Resolve SHALL pop head when resolve_valid && count != 0.
REQ-022 Update outputs SHALL be registered, valid exactly 1 cycle after accepted resolve; write_enabled is a 1-cycle pulse.
REQ-023 outcome = resolve_outcome; pc_bits_write = head pc; branch_miss = (head prediction != resolve_outcome), asserted only with write_enabled.
REQ-024 global_history_write = {head ghist[GLOBAL_HISTORY_LEN-2:0], resolve_outcome}; local_history_write = {head lhist[LOCAL_HISTORY_LEN-2:0], resolve_outcome}.
REQ-025 Data outputs SHALL hold last values when write_enabled = 0.
REQ-026 On mispredicted resolve, all younger entries SHALL be flushed in the same edge: count -> 0, read pointer = write pointer.
REQ-027 Push coincident with mispredicted resolve SHALL be dropped (flush wins); push with correct resolve SHALL both occur, count unchanged.
REQ-028 Push when full SHALL be ignored, even if a resolve frees an entry that cycle.
REQ-029 Resolve when empty SHALL produce no write_enabled, leave state unchanged, and set resolve_underflow until reset.
REQ-030 Pointers SHALL wrap modulo DEPTH; count SHALL never exceed DEPTH or underflow.

Reset
REQ-031 reset low SHALL asynchronously clear pointers, count, write_enabled, outcome, branch_miss, pc_bits_write, global_history_write, local_history_write, resolve_underflow to 0; push_ready = 1 following.
REQ-032 Reset mid-operation SHALL discard all entries; a resolve pending in the cut cycle produces no update.
REQ-033 Entry storage need not be reset.

Configuration
REQ-034 With macro BCQ_STATS_EN defined, outputs stat_resolved[15:0] and stat_miss[15:0] SHALL exist, incremented per accepted resolve / per miss, saturating at 16'hFFFF, cleared by reset.
REQ-035 Without BCQ_STATS_EN, those ports and counters SHALL be absent; all other behaviour identical.

Verification
REQ-036 Push pc 0x0010 pred 1, ghist 8'hA5; resolve outcome 1 -> next cycle write_enabled=1, branch_miss=0, pc_bits_write=0x0010, global_history_write=8'h4B.
REQ-037 Push 3 entries (pred 1,1,0); resolve head with outcome 0 -> branch_miss=1, count 3 -> 0, later resolve sets resolve_underflow=1.
REQ-038 Fill 8 entries -> push_ready=0, count=8; 9th push plus simultaneous correct resolve -> count=7, 9th entry absent.
REQ-039 Push 12 and resolve 12 correct branches interleaved -> pointers wrap, PCs emerge in push order, count returns 0.
REQ-040 Drive reset low mid-stream with count=5 -> count=0, write_enabled=0 immediately, no update after release.
REQ-041 With BCQ_STATS_EN: 4 resolves, 1 miss -> stat_resolved=4, stat_miss=1.
